// File: rtl/fetch_issue_q.sv
// fetch_issue_q: circular packet queue between fetch and the F/D latch.
// Ports: clk/clr (sync active-high clear); in_* = fetch offer with
//   in_valid/in_ready handshake; fd_* = head entry toward F/D latch,
//   fd_ld/fd_clr = latch load/clear, fd_stall = decode busy,
//   flush = squash all queued packets.
// Optional: define FETCH_ISSUE_BYPASS_EN to forward an incoming packet
//   straight to fd_* when the queue is empty (no storage write).
module fetch_issue_q #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_packet,
    input  logic [5:0]   in_BP_alias,
    input  logic         in_IE,
    input  logic [3:0]   in_IE_type,
    input  logic [31:0]  in_BR_pred_target,
    input  logic         in_BR_pred_T_NT,
    input  logic         fd_stall,
    input  logic         flush,
    output logic         fd_ld,
    output logic         fd_clr,
    output logic         fd_valid,
    output logic [127:0] fd_packet,
    output logic [5:0]   fd_BP_alias,
    output logic         fd_IE,
    output logic [3:0]   fd_IE_type,
    output logic [31:0]  fd_BR_pred_target,
    output logic         fd_BR_pred_T_NT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = 172;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [RW-1:0] mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [RW-1:0] in_rec;
    logic [RW-1:0] head_rec;
    logic [RW-1:0] out_rec;
    logic          empty;
    logic          byp;
    logic          accept;
    logic          enq;
    logic          deq;

    assign in_rec = {in_packet, in_BP_alias, in_IE, in_IE_type,
                     in_BR_pred_target, in_BR_pred_T_NT};

    assign head_rec = mem[head];
    assign empty    = (count == '0);

    assign in_ready = (state == RUN) & (count < FULL) & !clr;
    assign fd_ld    = !fd_stall | flush;
    assign fd_clr   = flush | clr;

`ifdef FETCH_ISSUE_BYPASS_EN
    // Empty queue and a latch ready to load: hand the offer straight over.
    assign byp = empty & (state == RUN) & in_valid & fd_ld & !flush & !clr;
`else
    assign byp = 1'b0;
`endif

    assign fd_valid = (!empty | byp) & !flush & !clr;

    // accept covers both stored and bypassed packets (for HALT entry).
    assign accept = in_valid & in_ready & !flush;
    assign enq    = accept & !byp;
    assign deq    = fd_ld & fd_valid & !empty;

    assign out_rec = !fd_valid ? '0 : (byp ? in_rec : head_rec);

    assign {fd_packet, fd_BP_alias, fd_IE, fd_IE_type,
            fd_BR_pred_target, fd_BR_pred_T_NT} = out_rec;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (accept & in_IE) begin
                        state_nxt = HALT;
                    end
                end
                HALT: begin
                    state_nxt = HALT;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not cleared; count/pointers define what is live.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= in_rec;
        end
    end

endmodule

// File: tb/tb_fetch_issue_q.sv
// tb_fetch_issue_q: self-checking bench for fetch_issue_q.
// Reference model: queue of records plus a halted flag.
module tb_fetch_issue_q;

    localparam int DEPTH = 4;
`ifdef FETCH_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_packet;
    logic [5:0]   in_BP_alias;
    logic         in_IE;
    logic [3:0]   in_IE_type;
    logic [31:0]  in_BR_pred_target;
    logic         in_BR_pred_T_NT;
    logic         fd_stall;
    logic         flush;
    logic         fd_ld;
    logic         fd_clr;
    logic         fd_valid;
    logic [127:0] fd_packet;
    logic [5:0]   fd_BP_alias;
    logic         fd_IE;
    logic [3:0]   fd_IE_type;
    logic [31:0]  fd_BR_pred_target;
    logic         fd_BR_pred_T_NT;

    logic [171:0] in_rec;
    logic [171:0] fd_rec;

    assign in_rec = {in_packet, in_BP_alias, in_IE, in_IE_type,
                     in_BR_pred_target, in_BR_pred_T_NT};
    assign fd_rec = {fd_packet, fd_BP_alias, fd_IE, fd_IE_type,
                     fd_BR_pred_target, fd_BR_pred_T_NT};

    fetch_issue_q #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .clr(clr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_packet(in_packet),
        .in_BP_alias(in_BP_alias),
        .in_IE(in_IE),
        .in_IE_type(in_IE_type),
        .in_BR_pred_target(in_BR_pred_target),
        .in_BR_pred_T_NT(in_BR_pred_T_NT),
        .fd_stall(fd_stall),
        .flush(flush),
        .fd_ld(fd_ld),
        .fd_clr(fd_clr),
        .fd_valid(fd_valid),
        .fd_packet(fd_packet),
        .fd_BP_alias(fd_BP_alias),
        .fd_IE(fd_IE),
        .fd_IE_type(fd_IE_type),
        .fd_BR_pred_target(fd_BR_pred_target),
        .fd_BR_pred_T_NT(fd_BR_pred_T_NT)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    logic [171:0] mq[$];
    bit           m_halt = 1'b0;

    bit           e_ready;
    bit           e_valid;
    bit           e_byp;
    logic [171:0] e_rec;

    function automatic logic [171:0] mk(input logic [127:0] p,
                                        input logic ie,
                                        input logic [3:0] t);
        return {p, 6'($urandom), ie, t, 32'($urandom), 1'($urandom)};
    endfunction

    task automatic set_rec(input logic [171:0] r);
        {in_packet, in_BP_alias, in_IE, in_IE_type,
         in_BR_pred_target, in_BR_pred_T_NT} = r;
    endtask

    function automatic void predict();
        bit ld;
        ld      = !fd_stall || flush;
        e_ready = !m_halt && (mq.size() < DEPTH) && !clr;
        e_byp   = BYP && mq.size() == 0 && !m_halt && in_valid
                  && ld && !flush && !clr;
        e_valid = (mq.size() != 0 || e_byp) && !flush && !clr;
        if (!e_valid) e_rec = '0;
        else if (e_byp) e_rec = in_rec;
        else e_rec = mq[0];
    endfunction

    // Advance the model by one edge, then the clock.
    task automatic tick();
        predict();
        if (clr || flush) begin
            mq.delete();
            m_halt = 1'b0;
        end else begin
            if (!fd_stall && mq.size() != 0) void'(mq.pop_front());
            if (in_valid && e_ready) begin
                if (!e_byp) mq.push_back(in_rec);
                if (in_IE) m_halt = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 1'b0; flush = 1'b0; in_valid = 1'b0; fd_stall = 1'b1;
        set_rec(mk(128'h0, 1'b0, 4'h0));
    endtask

    task automatic do_clr();
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        clr = 1'b1; in_valid = 1'b1; fd_stall = 1'b0;
        set_rec(mk(128'h77, 1'b0, 4'h0));
        for (int c = 0; c < 2; c++) begin
            #1;
            vecs++;
            if (in_ready !== 1'b0 || fd_valid !== 1'b0 || fd_clr !== 1'b1
                || fd_rec !== '0) begin
                errs++;
                $display("FAIL reset_hold c=%0d rdy=%b vld=%b clr=%b rec=%h",
                         c, in_ready, fd_valid, fd_clr, fd_rec);
            end
            tick();
        end
        clr = 1'b0; in_valid = 1'b0; fd_stall = 1'b1;
        #1;
        vecs++;
        if (fd_valid !== 1'b0 || in_ready !== 1'b1 || fd_clr !== 1'b0) begin
            errs++;
            $display("FAIL reset_release vld=%b rdy=%b clr=%b want 0 1 0",
                     fd_valid, in_ready, fd_clr);
        end
    endtask

    task automatic test_fill_drain();
        bit acc;
        do_clr();
        fd_stall = 1'b1;
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_rec(mk(128'(i), 1'b0, 4'h0));
            #1;
            vecs++;
            if (in_ready !== 1'b1) begin
                errs++;
                $display("FAIL fill_ready i=%0d got %b want 1", i, in_ready);
            end
            tick();
        end
        set_rec(mk(128'h5, 1'b0, 4'h0));
        for (int c = 0; c < 2; c++) begin
            #1;
            vecs++;
            if (in_ready !== 1'b0 || fd_valid !== 1'b1
                || fd_packet !== 128'h1) begin
                errs++;
                $display("FAIL full_hold rdy=%b vld=%b pkt=%h want 0 1 1",
                         in_ready, fd_valid, fd_packet);
            end
            tick();
        end
        fd_stall = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            vecs++;
            if (fd_valid !== 1'b1 || fd_packet !== 128'(k)) begin
                errs++;
                $display("FAIL drain k=%0d vld=%b pkt=%h", k, fd_valid,
                         fd_packet);
            end
            if (k == 1) begin
                vecs++;
                if (in_ready !== 1'b0) begin
                    errs++;
                    $display("FAIL drain_full_rdy got %b want 0", in_ready);
                end
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        #1;
        vecs++;
        if (fd_valid !== 1'b0) begin
            errs++;
            $display("FAIL drain_empty vld=%b want 0", fd_valid);
        end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int got = 0;
        do_clr();
        fd_stall = 1'b0;
        for (int c = 0; c < 40 && got < 10; c++) begin
            in_valid = (sent < 10);
            set_rec(mk(128'(sent + 1), 1'b0, 4'h0));
            #1;
            if (fd_valid && fd_ld) begin
                vecs++;
                if (fd_packet !== 128'(got + 1)) begin
                    errs++;
                    $display("FAIL wrap_order got %h want %0d", fd_packet,
                             got + 1);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        vecs++;
        if (got != 10) begin
            errs++;
            $display("FAIL wrap_count got %0d want 10", got);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_exception();
        logic [171:0] a;
        logic [171:0] b;
        do_clr();
        a = mk(128'hA, 1'b0, 4'h0);
        b = mk(128'hB, 1'b1, 4'h3);
        fd_stall = 1'b1;
        in_valid = 1'b1;
        set_rec(a);
        tick();
        set_rec(b);
        tick();
        set_rec(mk(128'hC, 1'b0, 4'h0));
        #1;
        vecs++;
        if (in_ready !== 1'b0) begin
            errs++;
            $display("FAIL exc_refuse rdy=%b want 0", in_ready);
        end
        tick();
        fd_stall = 1'b0;
        #1;
        vecs++;
        if (fd_valid !== 1'b1 || fd_rec !== a) begin
            errs++;
            $display("FAIL exc_head_a vld=%b rec=%h want %h", fd_valid,
                     fd_rec, a);
        end
        tick();
        #1;
        vecs++;
        if (fd_valid !== 1'b1 || fd_rec !== b || fd_IE_type !== 4'h3) begin
            errs++;
            $display("FAIL exc_head_b vld=%b rec=%h want %h", fd_valid,
                     fd_rec, b);
        end
        tick();
        #1;
        vecs++;
        if (fd_valid !== 1'b0 || in_ready !== 1'b0) begin
            errs++;
            $display("FAIL exc_halted vld=%b rdy=%b want 0 0", fd_valid,
                     in_ready);
        end
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        vecs++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL exc_resume rdy=%b want 1", in_ready);
        end
    endtask

    task automatic test_flush();
        do_clr();
        fd_stall = 1'b1;
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_rec(mk(128'(16 + i), 1'b0, 4'h0));
            tick();
        end
        set_rec(mk(128'h99, 1'b0, 4'h0));
        flush = 1'b1;
        #1;
        vecs++;
        if (fd_clr !== 1'b1 || fd_valid !== 1'b0 || fd_ld !== 1'b1
            || fd_rec !== '0) begin
            errs++;
            $display("FAIL flush_now clr=%b vld=%b ld=%b rec=%h",
                     fd_clr, fd_valid, fd_ld, fd_rec);
        end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        vecs++;
        if (fd_valid !== 1'b0 || in_ready !== 1'b1 || fd_clr !== 1'b0) begin
            errs++;
            $display("FAIL flush_after vld=%b rdy=%b clr=%b want 0 1 0",
                     fd_valid, in_ready, fd_clr);
        end
    endtask

    task automatic test_latency();
        do_clr();
        fd_stall = 1'b0;
        in_valid = 1'b1;
        set_rec(mk(128'hAB, 1'b0, 4'h0));
        #1;
        vecs++;
        if (fd_valid !== BYP || (BYP && fd_packet !== 128'hAB)) begin
            errs++;
            $display("FAIL lat_same vld=%b pkt=%h want vld %b", fd_valid,
                     fd_packet, BYP);
        end
        tick();
        in_valid = 1'b0;
        #1;
        vecs++;
        if (fd_valid !== !BYP || (!BYP && fd_packet !== 128'hAB)) begin
            errs++;
            $display("FAIL lat_next vld=%b pkt=%h want vld %b", fd_valid,
                     fd_packet, !BYP);
        end
        tick();
        #1;
        vecs++;
        if (fd_valid !== 1'b0) begin
            errs++;
            $display("FAIL lat_empty vld=%b want 0", fd_valid);
        end
    endtask

    task automatic test_clr_mid();
        do_clr();
        fd_stall = 1'b1;
        in_valid = 1'b1;
        set_rec(mk(128'h31, 1'b1, 4'h7));
        tick();
        set_rec(mk(128'h32, 1'b0, 4'h0));
        clr = 1'b1;
        flush = 1'b1;
        fd_stall = 1'b0;
        #1;
        vecs++;
        if (in_ready !== 1'b0 || fd_valid !== 1'b0 || fd_clr !== 1'b1) begin
            errs++;
            $display("FAIL clr_mid rdy=%b vld=%b clr=%b want 0 0 1",
                     in_ready, fd_valid, fd_clr);
        end
        tick();
        clr = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        vecs++;
        if (fd_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL clr_mid_after vld=%b rdy=%b want 0 1",
                     fd_valid, in_ready);
        end
    endtask

    task automatic test_random();
        int n = 0;
        do_clr();
        for (int c = 0; c < 400; c++) begin
            clr      = ($urandom_range(0, 99) < 2);
            flush    = ($urandom_range(0, 99) < 5);
            fd_stall = ($urandom_range(0, 99) < 35);
            in_valid = ($urandom_range(0, 99) < 70);
            set_rec(mk(128'(++n), $urandom_range(0, 99) < 8,
                       4'($urandom)));
            #1;
            predict();
            vecs++;
            if (in_ready !== e_ready || fd_valid !== e_valid
                || fd_rec !== e_rec) begin
                errs++;
                $display("FAIL rand c=%0d rdy=%b/%b vld=%b/%b rec=%h/%h",
                         c, in_ready, e_ready, fd_valid, e_valid,
                         fd_rec, e_rec);
            end
            vecs++;
            if (fd_ld !== (!fd_stall || flush) || fd_clr !== (flush || clr))
            begin
                errs++;
                $display("FAIL rand_ctl c=%0d ld=%b clr=%b", c, fd_ld,
                         fd_clr);
            end
            tick();
        end
    endtask

    initial begin
        idle();
        clr = 1'b1;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_exception();
        test_flush();
        test_latency();
        test_clr_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
